// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared FSM encodings and byte-enable legality for the data-memory responder
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_B1   = 4'b0010;
   localparam logic [3:0] BE_B2   = 4'b0100;
   localparam logic [3:0] BE_B3   = 4'b1000;
   localparam logic [3:0] BE_H0   = 4'b0011;
   localparam logic [3:0] BE_H1   = 4'b1100;
   localparam logic [3:0] BE_W    = 4'b1111;

   // Only naturally aligned byte, halfword and word lane patterns are accepted.
   function automatic logic be_legal(input logic [3:0] we);
      return we inside {BE_NONE, BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W};
   endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// dmem_bank_ram: four byte-lane synchronous RAM with read-before-write and per-lane write mask
module dmem_bank_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              re,
   input  logic [ADDR_W-1:0] idx,
   input  logic [3:0]        wmask,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem_q [2**ADDR_W];
      logic [7:0] rd_q;
      // Read captures the old byte in the same edge that may overwrite it.
      always_ff @(posedge clk) begin
         if (re) rd_q <= mem_q[idx];
         if (wmask[l]) mem_q[idx] <= wdata[8*l +: 8];
      end
      assign rdata[8*l +: 8] = rd_q;
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-port slave with wait states, stall generation and access checks
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int WAIT_CYC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err
);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  we_q;
   logic [31:2] addr_q;
   logic [31:0] wdata_q;
   logic        zero_q;
   logic        err_q;
   logic        access;
   logic        bad;
   logic [31:0] ram_rdata;
   logic        unused_ok;

   assign unused_ok = ^addr[1:0];
   assign access    = state_q == WAIT && cnt_q == 4'd0;
   assign bad       = !be_legal(we_q) || addr_q[31:ADDR_W+2] != '0;
   assign stall     = rst && ((state_q == IDLE && en) || state_q == WAIT);
   assign rdata     = zero_q ? '0 : ram_rdata;
   assign err       = err_q;

   dmem_bank_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .re    (access),
      .idx   (addr_q[ADDR_W+1:2]),
      .wmask (access && !bad ? we_q : 4'b0000),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // Request latch, wait countdown and result flags; a rejected access zeroes rdata until the next one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         zero_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (en) begin
               addr_q  <= addr[31:2];
               we_q    <= we;
               wdata_q <= wdata;
               cnt_q   <= 4'(WAIT_CYC);
               state_q <= WAIT;
            end
            WAIT: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            else begin
               zero_q  <= bad;
               err_q   <= bad;
               state_q <= DONE;
            end
            DONE: begin
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
